// File: rtl/mult_op_sequencer.sv
// mult_op_sequencer
// Upstream control stage for shift_add_multiplier. It takes operand pairs from a
// valid/ready stream, holds the multiplier in reset while it is idle, and releases
// it to compute. It then waits for end_op, or gives up after TIMEOUT cycles, and
// presents the product (or a timeout flag) on a valid/ready output stream.
module mult_op_sequencer #(
    parameter int WIDTH        = 8,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_rst,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    input  logic [2*WIDTH-1:0]   mul_result,
    input  logic                 mul_end_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_timeout,
    output logic                 busy,
    output logic [15:0]          op_count
);

    // One counter serves both the START hold and the WAIT timeout, so it is sized for the larger.
    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    // The timeout fires only on the last WAIT cycle, and only when end_op is absent.
    assign timed_out = (cnt == TO_LAST) && !mul_end_op;

    // Control FSM and the shared cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == START_LAST) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (mul_end_op || timed_out) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand holding registers: loaded on accept, kept until the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else if (state == S_IDLE && in_valid) begin
            mul_multiplicand <= in_a;
            mul_multiplier   <= in_b;
        end
    end

    // Result capture: end_op takes priority over a coincident timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_product <= '0;
            out_timeout <= 1'b0;
        end else if (state == S_WAIT) begin
            if (mul_end_op) begin
                out_product <= mul_result;
                out_timeout <= 1'b0;
            end else if (timed_out) begin
                out_product <= '0;
                out_timeout <= 1'b1;
            end
        end
    end

    // Count completed output handshakes; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (state == S_DONE && out_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

    // Handshake and multiplier control decode purely from the registered state.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign mul_rst   = (state != S_WAIT);

endmodule

// File: tb/tb_mult_op_sequencer.sv
// tb_mult_op_sequencer
// Directed bench for mult_op_sequencer. A small multiplier stub answers after a
// programmable number of WAIT cycles, or never, or with a forced result value.
module tb_mult_op_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mul_rst;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic [15:0] mul_result;
    logic        mul_end_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_timeout;
    logic        busy;
    logic [15:0] op_count;

    // Multiplier stub controls
    logic [7:0]  stub_cnt;
    logic [7:0]  stub_lat;
    logic        stub_ovr;
    logic [15:0] stub_res;

    int checks = 0;
    int errors = 0;
    int lat, low, rdy;

    mult_op_sequencer #(
        .WIDTH        (8),
        .START_CYCLES (2),
        .TIMEOUT      (20)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_rst          (mul_rst),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_result       (mul_result),
        .mul_end_op       (mul_end_op),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_timeout      (out_timeout),
        .busy             (busy),
        .op_count         (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub: counts cycles since leaving reset; signals done when the count reaches stub_lat.
    always @(posedge clk) begin
        if (mul_rst) stub_cnt <= 8'd0;
        else         stub_cnt <= stub_cnt + 8'd1;
    end
    assign mul_end_op = !mul_rst && (stub_cnt == stub_lat);
    assign mul_result = stub_ovr ? stub_res
                                 : ({8'd0, mul_multiplicand} * {8'd0, mul_multiplier});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair across the next rising edge, then drop in_valid.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Sample on falling edges until out_valid; reports falling edges elapsed,
    // samples with mul_rst low and samples with in_ready high.
    task automatic wait_valid(output int n, output int nlow, output int nrdy);
        bit seen;
        seen = 1'b0;
        n    = 0;
        nlow = 0;
        nrdy = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (mul_rst === 1'b0)  nlow++;
            if (in_ready === 1'b1) nrdy++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("valid_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b0;
        stub_lat  = 8'd3;
        stub_ovr  = 1'b0;
        stub_res  = 16'd0;

        // Reset state
        #12;
        chk("rst_mul_rst", mul_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_timeout", out_timeout, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_operand_a", mul_multiplicand, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_busy", busy, 0);

        // 3 x 5, stub answers after 4 WAIT cycles: latency 2 + 4 + 1
        out_ready = 1'b1;
        start_op(8'd3, 8'd5);
        wait_valid(lat, low, rdy);
        chk("t1_latency", lat, 7);
        chk("t1_mul_rst_low_cycles", low, 4);
        chk("t1_in_ready_cycles", rdy, 0);
        chk("t1_product", out_product, 15);
        chk("t1_timeout", out_timeout, 0);
        chk("t1_mul_rst_done", mul_rst, 1);
        @(negedge clk);
        chk("t1_single_valid", out_valid, 0);
        chk("t1_op_count", op_count, 1);
        chk("t1_idle_ready", in_ready, 1);
        chk("t1_operand_held", mul_multiplicand, 3);

        // Back-to-back 255 x 255 then 0 x 123 with in_valid held high
        in_a     = 8'd255;
        in_b     = 8'd255;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a = 8'd0;
        in_b = 8'd123;
        wait_valid(lat, low, rdy);
        chk("t2a_product", out_product, 65025);
        chk("t2a_in_ready_cycles", rdy, 0);
        wait_valid(lat, low, rdy);
        in_valid = 1'b0;
        chk("t2b_product", out_product, 0);
        chk("t2b_latency", lat, 8);
        chk("t2b_in_ready_cycles", rdy, 1);
        @(negedge clk);
        chk("t2_op_count", op_count, 3);
        chk("t2_operand_b", mul_multiplier, 123);

        // 127 x 201 with the consumer stalling for 5 cycles
        out_ready = 1'b0;
        start_op(8'd127, 8'd201);
        wait_valid(lat, low, rdy);
        chk("t3_latency", lat, 7);
        chk("t3_product", out_product, 25527);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_product", out_product, 25527);
            chk("t3_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_valid", out_valid, 0);
        chk("t3_idle_busy", busy, 0);
        chk("t3_op_count", op_count, 4);

        // Stub never finishes: timeout after 20 WAIT cycles, 2 + 20 + 1
        stub_lat = 8'd255;
        start_op(8'd13, 8'd11);
        wait_valid(lat, low, rdy);
        chk("t4_latency", lat, 23);
        chk("t4_mul_rst_low_cycles", low, 20);
        chk("t4_timeout", out_timeout, 1);
        chk("t4_product", out_product, 0);
        @(negedge clk);
        chk("t4_op_count", op_count, 5);

        // end_op on the last WAIT cycle wins over the timeout
        stub_lat = 8'd19;
        stub_ovr = 1'b1;
        stub_res = 16'd143;
        start_op(8'd13, 8'd11);
        wait_valid(lat, low, rdy);
        chk("t5_latency", lat, 23);
        chk("t5_product", out_product, 143);
        chk("t5_timeout", out_timeout, 0);
        @(negedge clk);
        chk("t5_op_count", op_count, 6);

        // Reset during WAIT aborts the operation
        stub_lat = 8'd3;
        stub_ovr = 1'b0;
        start_op(8'd10, 8'd12);
        repeat (3) @(negedge clk);
        chk("t6_in_wait", mul_rst, 0);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_mul_rst", mul_rst, 1);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_op_count", op_count, 0);
        @(negedge clk) rst = 1'b1;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) low++;
        end
        chk("t6_no_valid_after_abort", low, 0);
        start_op(8'd10, 8'd12);
        wait_valid(lat, low, rdy);
        chk("t6_product", out_product, 120);
        @(negedge clk);
        chk("t6_op_count", op_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
